instr_mem_prog: RTL and testbench

- Parametrised, run-time programmable instruction memory for the MIPS fetch stage.
- Replaces the fixed reset-preloaded ROM with a memory that clears itself after reset and is loaded over a program port, from the NoC/debug side.
- Adds fetch stall/flush, a valid flag and PC fault detection.
- Synchronous read; feeds the IF/ID boundary.

---
 rtl/instr_mem_prog_if.sv | 30 +++
 rtl/instr_mem_prog.sv | 122 ++++++++++++
 tb/tb_instr_mem_prog.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_prog_if.sv
// Fetch and program-load port bundle for instr_mem_prog.
// The master side drives PC/stall/flush and program writes; the slave side is the memory.
interface instr_mem_prog_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PAW    = 4
);
  logic [ADDR_W-1:0] PC_F;
  logic              stall_F;
  logic              flush_F;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fetch_fault;
  logic              prog_en;
  logic              prog_we;
  logic [PAW-1:0]    prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready;
  logic              init_done;

  modport master (
    output PC_F, stall_F, flush_F, prog_en, prog_we, prog_addr, prog_data,
    input  instruction, instr_valid, fetch_fault, prog_ready, init_done
  );

  modport slave (
    input  PC_F, stall_F, flush_F, prog_en, prog_we, prog_addr, prog_data,
    output instruction, instr_valid, fetch_fault, prog_ready, init_done
  );
endinterface

// File: rtl/instr_mem_prog.sv
// Run-time programmable instruction memory for the fetch stage: self-clears after reset,
// loads over the program port, and fetches with 1-cycle latency plus stall/flush/fault.
//
// state  | meaning
// S_INIT | writing NOP to every word, one per cycle, after reset
// S_RUN  | normal fetch; prog_en requests LOAD
// S_LOAD | program writes accepted, fetch outputs forced to bubble
module instr_mem_prog #(
  parameter int              DATA_W = 32,
  parameter int              DEPTH  = 16,
  parameter int              ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP  = '0
) (
  input logic             clk,
  input logic             rst,
  instr_mem_prog_if.slave bus
);
  localparam int PAW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_LOAD} state_t;

  state_t            state_q, state_d;
  logic [PAW-1:0]    clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [PAW-1:0]    mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] word;
  logic              misaligned;
  logic              out_of_range;

  // Full-width range compare so high PC bits never alias onto low words.
  assign word         = bus.PC_F >> 2;
  assign misaligned   = bus.PC_F[1:0] != 2'b00;
  assign out_of_range = word >= ADDR_W'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      clr_idx_q <= '0;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q;
    mem_wdata = NOP;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        instr_d   = NOP;
        valid_d   = 1'b0;
        fault_d   = 1'b0;
        if (clr_idx_q == PAW'(DEPTH - 1)) begin
          state_d   = S_RUN;
          clr_idx_d = '0;
        end
      end
      S_RUN: begin
        if (bus.prog_en) state_d = S_LOAD;
        if (bus.flush_F) begin
          instr_d = NOP;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end else if (!bus.stall_F) begin
          if (misaligned || out_of_range) begin
            instr_d = NOP;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            instr_d = mem[word[PAW-1:0]];
            valid_d = 1'b1;
            fault_d = 1'b0;
          end
        end
      end
      S_LOAD: begin
        instr_d = NOP;
        valid_d = 1'b0;
        fault_d = 1'b0;
        if (bus.prog_we && (int'(bus.prog_addr) < DEPTH)) begin
          mem_we    = 1'b1;
          mem_waddr = bus.prog_addr;
          mem_wdata = bus.prog_data;
        end
        if (!bus.prog_en) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Held off while rst is low so reset alone never modifies the array.
  always_ff @(posedge clk) begin
    if (mem_we && rst) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.prog_ready  = (state_q == S_LOAD);
  assign bus.init_done   = (state_q != S_INIT);
endmodule

// File: tb/tb_instr_mem_prog.sv
// Randomized bench for instr_mem_prog: DEPTH=16 instance checked cycle by cycle against a
// behavioural model, plus a directed DEPTH=12 instance for non-power-of-2 bounds.
module tb_instr_mem_prog;
  localparam int DA = 16;
  localparam int DB = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_mem_prog_if #(.DATA_W(32), .ADDR_W(32), .PAW(4)) a ();
  instr_mem_prog_if #(.DATA_W(32), .ADDR_W(32), .PAW(4)) b ();

  instr_mem_prog #(.DATA_W(32), .DEPTH(DA), .ADDR_W(32), .NOP(32'h0)) dut_a (
    .clk(clk), .rst(rst), .bus(a));
  instr_mem_prog #(.DATA_W(32), .DEPTH(DB), .ADDR_W(32), .NOP(32'h0)) dut_b (
    .clk(clk), .rst(rst), .bus(b));

  int checks = 0;
  int failures = 0;

  // Behavioural reference for the DEPTH=16 instance
  logic [31:0] m_mem [DA];
  int          m_init_left;
  bit          m_loading;
  logic [31:0] e_instr;
  bit          e_valid, e_fault;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DA; i++) m_mem[i] = 32'h0;
    m_init_left = DA;
    m_loading   = 1'b0;
    e_instr     = 32'h0;
    e_valid     = 1'b0;
    e_fault     = 1'b0;
  endtask

  task automatic predict();
    longint unsigned pc;
    pc = a.PC_F;
    if (m_init_left > 0) begin
      m_init_left--;
      e_instr = 0; e_valid = 0; e_fault = 0;
    end else if (m_loading) begin
      if (a.prog_we && a.prog_addr < DA) m_mem[a.prog_addr] = a.prog_data;
      e_instr = 0; e_valid = 0; e_fault = 0;
      if (!a.prog_en) m_loading = 1'b0;
    end else begin
      if (a.prog_en) m_loading = 1'b1;
      if (a.flush_F) begin
        e_instr = 0; e_valid = 0; e_fault = 0;
      end else if (!a.stall_F) begin
        if ((pc % 4) != 0 || (pc / 4) >= DA) begin
          e_instr = 0; e_valid = 0; e_fault = 1;
        end else begin
          e_instr = m_mem[pc / 4]; e_valid = 1; e_fault = 0;
        end
      end
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk); #1;
    check_val("instruction", a.instruction, e_instr);
    check_val("instr_valid", a.instr_valid, e_valid);
    check_val("fetch_fault", a.fetch_fault, e_fault);
    check_val("prog_ready",  a.prog_ready,  m_loading);
    check_val("init_done",   a.init_done,   m_init_left == 0);
  endtask

  task automatic drive(input bit en, input bit we, input logic [3:0] addr, input logic [31:0] data,
                       input logic [31:0] pc, input bit stall, input bit flush);
    a.prog_en = en; a.prog_we = we; a.prog_addr = addr; a.prog_data = data;
    a.PC_F = pc; a.stall_F = stall; a.flush_F = flush;
  endtask

  function automatic logic [31:0] pick_pc();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return 32'($urandom_range(0, DA - 1) * 4);
    else if (r <= 7) return 32'($urandom_range(0, DA - 1) * 4 + $urandom_range(1, 3));
    else if (r == 8) return $urandom;
    else             return 32'((DA + $urandom_range(0, 64)) * 4);
  endfunction

  task automatic cyc_b();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_list [5];
    drive(0, 0, 0, 0, 0, 0, 0);
    b.prog_en = 0; b.prog_we = 0; b.prog_addr = 0; b.prog_data = 0;
    b.PC_F = 0; b.stall_F = 0; b.flush_F = 0;

    // Reset state
    @(negedge clk); rst = 1'b0; #1;
    model_reset();
    check_val("rst_instr", a.instruction, 32'h0);
    check_val("rst_valid", a.instr_valid, 1'b0);
    check_val("rst_fault", a.fetch_fault, 1'b0);
    check_val("rst_ready", a.prog_ready, 1'b0);
    check_val("rst_done",  a.init_done, 1'b0);
    @(negedge clk); rst = 1'b1;

    // INIT: random program/fetch traffic must be ignored
    for (int i = 0; i < DA; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom, pick_pc(), 0, 0);
      tick();
    end
    check_val("init_done_rise", a.init_done, 1'b1);

    // Program two words; the second write lands in the exit cycle
    drive(1, 0, 0, 0, 32'h0, 0, 0);            tick();
    drive(1, 1, 0, 32'h9000_1089, 32'h0, 0, 0); tick();
    drive(0, 1, 1, 32'h9000_5089, 32'h0, 0, 0); tick();
    drive(0, 0, 0, 0, 32'h0, 0, 0);            tick();
    check_val("word0", a.instruction, 32'h9000_1089);
    drive(0, 0, 0, 0, 32'h4, 0, 0);            tick();
    check_val("word1", a.instruction, 32'h9000_5089);
    check_val("word1_valid", a.instr_valid, 1'b1);

    // Fault addresses
    pc_list = '{32'h2, 32'h40, 32'h100, 32'h8000_0000, 32'hFFFF_FFFC};
    foreach (pc_list[i]) begin
      drive(0, 0, 0, 0, pc_list[i], 0, 0); tick();
      check_val("fault_pc", a.fetch_fault, 1'b1);
    end

    // Stall holds, flush beats stall
    drive(0, 0, 0, 0, 32'h4, 0, 0); tick();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 32'(4 * i + 4), 1, 0); tick();
      check_val("stall_hold", a.instruction, 32'h9000_5089);
    end
    drive(0, 0, 0, 0, 32'h0, 1, 1); tick();
    check_val("flush_valid", a.instr_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit en;
      en = m_loading ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
      drive(en, $urandom_range(0, 1), 4'($urandom), $urandom, pick_pc(),
            $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0);
      tick();
    end

    // Reset in the middle of LOAD after two writes
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 32'hDEAD_0001, 0, 0, 0); tick();
    drive(1, 1, 2, 32'hDEAD_0002, 0, 0, 0); tick();
    #2 rst = 1'b0; #1;
    model_reset();
    check_val("midload_ready", a.prog_ready, 1'b0);
    check_val("midload_done",  a.init_done,  1'b0);
    check_val("midload_valid", a.instr_valid, 1'b0);
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DA; i++) tick();
    drive(0, 0, 0, 0, 32'h0, 0, 0); tick();
    check_val("cleared_w0", a.instruction, 32'h0);
    drive(0, 0, 0, 0, 32'h8, 0, 0); tick();
    check_val("cleared_w2", a.instruction, 32'h0);

    // DEPTH=12 instance: bounds and discarded out-of-range writes
    b.prog_en = 1; cyc_b();
    check_val("b_ready", b.prog_ready, 1'b1);
    b.prog_we = 1; b.prog_addr = 4'd11; b.prog_data = 32'hABCD_0011; cyc_b();
    b.prog_addr = 4'd13; b.prog_data = 32'h5555_AAAA; cyc_b();
    b.prog_we = 0; b.prog_en = 0; cyc_b();
    for (int w = 0; w < DB; w++) begin
      b.PC_F = 32'(w * 4); cyc_b();
      check_val("b_word", b.instruction, (w == 11) ? 32'hABCD_0011 : 32'h0);
      check_val("b_valid", b.instr_valid, 1'b1);
    end
    b.PC_F = 32'd48; cyc_b();
    check_val("b_fault48", b.fetch_fault, 1'b1);
    b.PC_F = 32'd52; cyc_b();
    check_val("b_fault52", b.fetch_fault, 1'b1);
    check_val("b_fault_instr", b.instruction, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
